// File: rtl/elev_pkg.sv
// elev_pkg: shared floor count, floor code type and arbiter state encoding.
package elev_pkg;
    localparam int NUM_FLOORS = 7;
    typedef logic [2:0] floor_t;
    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer plus counting debouncer for one button, with a registered rise pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          rise_q;
    logic          differ;
    logic          done;
    assign differ = sync_q[1] != level_q;
    // the level flips on the edge that completes the N-th consecutive differing cycle
    assign done   = differ && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    assign rise   = rise_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            cnt_q   <= differ && !done ? cnt_q + 1'b1 : '0;
            level_q <= done ? sync_q[1] : level_q;
            rise_q  <= done && sync_q[1];
        end
    end
endmodule

// File: rtl/floor_request_encoder.sv
// floor_request_encoder: debounced call buttons latched into pending requests, offered round-robin on a valid/ready port.
// Optional CUR_FLOOR_FILTER_EN adds cur_floor and suppresses presses for the floor the car is at.
module floor_request_encoder #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int NUM_FLOORS      = elev_pkg::NUM_FLOORS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] btn,
`ifdef CUR_FLOOR_FILTER_EN
    input  logic [2:0]            cur_floor,
`endif
    input  logic                  req_ready,
    output logic                  req_valid,
    output logic [2:0]            req_floor,
    output logic [NUM_FLOORS-1:0] pending
);
    import elev_pkg::*;
    state_t                state_q;
    floor_t                floor_q;
    floor_t                last_q;
    floor_t                sel;
    floor_t                idx;
    logic [NUM_FLOORS-1:0] pend_q;
    logic [NUM_FLOORS-1:0] pend_d;
    logic [NUM_FLOORS-1:0] rise;
    logic [NUM_FLOORS-1:0] mask;
    logic [NUM_FLOORS-1:0] clr;
    logic                  accept;
    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .rise (rise[i])
        );
    end
`ifdef CUR_FLOOR_FILTER_EN
    assign mask = cur_floor != 3'd0 ? NUM_FLOORS'(1) << (cur_floor - 3'd1) : '0;
`else
    assign mask = '0;
`endif
    assign accept    = state_q == OFFER && req_ready;
    assign clr       = accept ? NUM_FLOORS'(1) << (floor_q - 3'd1) : '0;
    // set after clear so a fresh press landing on the accept edge survives
    assign pend_d    = (pend_q & ~clr) | (rise & ~mask);
    assign req_valid = state_q == OFFER;
    assign req_floor = floor_q;
    assign pending   = pend_q;
    always_comb begin
        sel = '0;
        idx = '0;
        for (int k = NUM_FLOORS; k >= 1; k--) begin
            idx = 3'((int'(last_q) + k - 1) % NUM_FLOORS);
            if (pend_q[idx]) sel = idx + 3'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            floor_q <= '0;
            last_q  <= floor_t'(NUM_FLOORS);
            pend_q  <= '0;
        end else begin
            pend_q <= pend_d;
            if (state_q == IDLE && |pend_q) begin
                state_q <= OFFER;
                floor_q <= sel;
            end else if (accept) begin
                state_q <= IDLE;
                last_q  <= floor_q;
            end
        end
    end
endmodule

// File: tb/tb_floor_request_encoder.sv
// tb_floor_request_encoder: directed scoreboard bench for floor_request_encoder with DEBOUNCE_CYCLES=4.
module tb_floor_request_encoder;
    logic       clk;
    logic       rst;
    logic [6:0] btn;
    logic       req_ready;
    logic       req_valid;
    logic [2:0] req_floor;
    logic [6:0] pending;
`ifdef CUR_FLOOR_FILTER_EN
    logic [2:0] cur_floor;
`endif
    logic [2:0] q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         grants = 0;
    int         snap;
    logic       prev_v = 0;
    logic       prev_r = 0;
    logic       prev_acc = 0;
    logic [2:0] prev_f = 0;

    floor_request_encoder #(.DEBOUNCE_CYCLES(4), .NUM_FLOORS(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
`ifdef CUR_FLOOR_FILTER_EN
        .cur_floor (cur_floor),
`endif
        .req_ready (req_ready),
        .req_valid (req_valid),
        .req_floor (req_floor),
        .pending   (pending)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (q.size() == 0 && !req_valid) break;
            step(1);
        end
        chk(tag, 32'(q.size()), 0);
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !req_valid; i++) step(1);
    endtask

    // scoreboard: every accepted handshake must match the next expected floor
    always @(negedge clk) begin
        if (rst) begin
            prev_v   <= 0;
            prev_r   <= 0;
            prev_acc <= 0;
        end else begin
            if (prev_acc) chk("gap_after_accept", 32'(req_valid), 0);
            if (req_valid && prev_v && !prev_r) chk("hold_floor", 32'(req_floor), 32'(prev_f));
            if (req_valid && req_ready) begin
                grants <= grants + 1;
                if (q.size() == 0) chk("unexpected_grant", 32'(req_floor), 0);
                else chk("grant_floor", 32'(req_floor), 32'(q.pop_front()));
            end
            prev_v   <= req_valid;
            prev_r   <= req_ready;
            prev_f   <= req_floor;
            prev_acc <= req_valid && req_ready;
        end
    end

    initial begin
        rst = 0;
        btn = '0;
        req_ready = 0;
`ifdef CUR_FLOOR_FILTER_EN
        cur_floor = '0;
`endif
        #1 rst = 1;
        #1;
        chk("rst_valid", 32'(req_valid), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_floor", 32'(req_floor), 0);
        step(3);
        rst = 0;
        step(2);

        // simultaneous presses from reset: round-robin starts at floor 1
        req_ready = 1;
        q.push_back(3'd2); q.push_back(3'd5); q.push_back(3'd7);
        btn = 7'b1010010;
        step(10);
        btn = '0;
        drain("multi_drain", 40);
        chk("multi_pending", 32'(pending), 0);

        // latency: rise on edge 6, pending on edge 7, valid on edge 8, accept on edge 9
        btn = 7'b0000100;
        step(6);
        chk("lat_pend_early", 32'(pending), 0);
        step(1);
        chk("lat_pend", 32'(pending), 32'h04);
        chk("lat_valid_early", 32'(req_valid), 0);
        q.push_back(3'd3);
        step(1);
        chk("lat_valid", 32'(req_valid), 1);
        chk("lat_floor", 32'(req_floor), 3);
        step(1);
        chk("lat_clear", 32'(pending), 0);
        step(1);
        btn = '0;
        step(20);
        drain("single_drain", 10);
        chk("single_pending", 32'(pending), 0);

        // a 3-cycle glitch is one short of the debounce window
        snap = grants;
        btn = 7'b0000001;
        step(3);
        btn = '0;
        step(20);
        chk("glitch_pending", 32'(pending), 0);
        chk("glitch_grants", 32'(grants), 32'(snap));

        // exactly 4 cycles is enough
        q.push_back(3'd6);
        btn = 7'b0100000;
        step(4);
        btn = '0;
        drain("edge_drain", 30);

        // stall: floor 4 held while floor 1 arrives, then wrap to 1
        req_ready = 0;
        btn = 7'b0001000;
        step(10);
        btn = '0;
        wait_valid(20);
        chk("stall_valid", 32'(req_valid), 1);
        chk("stall_floor", 32'(req_floor), 4);
        btn = 7'b0000001;
        step(10);
        btn = '0;
        step(10);
        chk("stall_hold_floor", 32'(req_floor), 4);
        chk("stall_pending", 32'(pending), 32'h09);
        q.push_back(3'd4); q.push_back(3'd1);
        req_ready = 1;
        drain("wrap_drain", 20);
        chk("wrap_pending", 32'(pending), 0);

        // asynchronous reset during an offer discards everything
        req_ready = 0;
        btn = 7'b0100001;
        step(10);
        btn = '0;
        wait_valid(20);
        chk("pre_rst_floor", 32'(req_floor), 6);
        rst = 1;
        #2;
        chk("async_valid", 32'(req_valid), 0);
        chk("async_pending", 32'(pending), 0);
        chk("async_floor", 32'(req_floor), 0);
        step(2);
        rst = 0;
        step(1);
        q.delete();
        req_ready = 1;
        q.push_back(3'd2);
        btn = 7'b0000010;
        step(10);
        btn = '0;
        drain("post_rst_drain", 20);
        chk("post_rst_pending", 32'(pending), 0);

`ifdef CUR_FLOOR_FILTER_EN
        cur_floor = 3'd3;
        q.push_back(3'd4);
        btn = 7'b0000100;
        step(10);
        btn = '0;
        step(5);
        btn = 7'b0001000;
        step(10);
        btn = '0;
        drain("filter_drain", 30);
        chk("filter_pending", 32'(pending), 0);
`endif

        step(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/floor_request_encoder.md
FLOOR_REQUEST_ENCODER -- requirements
Module: floor_request_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, consecutive stable cycles required before a button level change is accepted.
REQ-002 Parameter NUM_FLOORS, default 7, number of floor buttons; floor codes 1..NUM_FLOORS.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 btn  in  7  raw, asynchronous, active-high call buttons; bit i-1 = floor i.
REQ-006 req_ready  in  1  consumer accepts req_floor when high with req_valid.
REQ-007 req_valid  out  1  req_floor holds a pending floor request.
REQ-008 req_floor  out  3  encoded floor, 1..7; value 0 never driven while req_valid=1.
REQ-009 pending  out  7  latched, not-yet-accepted requests; bit i-1 = floor i.

Function
REQ-010 Each btn bit shall pass a 2-flop synchronizer before any other use.
REQ-011 Debounced level shall change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to equality shall restart the count.
REQ-012 A 0->1 debounced transition shall set the matching pending bit on the next edge; 1->0 transitions and held buttons shall have no effect.
REQ-013 A press for a floor whose pending bit is already set shall have no effect.
REQ-014 Arbiter FSM states: IDLE, OFFER; IDLE->OFFER when pending!=0, OFFER->IDLE on req_valid&&req_ready.
REQ-015 On IDLE->OFFER, the selected floor shall be the first set pending bit searching ascending from last_grant+1, wrapping 7->1.
REQ-016 req_valid shall be high exactly in OFFER; req_floor shall stay stable while req_valid=1 and req_ready=0.
REQ-017 On acceptance, the granted pending bit shall clear and last_grant shall load req_floor on the same edge; req_valid is low the next cycle (max one grant per 2 cycles).
REQ-018 If a new debounced rising edge for the granted floor coincides with its acceptance, the pending bit shall remain set.
REQ-019 Latency: debounced rising edge at cycle N -> pending set at N+1 -> req_valid high at N+2 when IDLE.
REQ-020 req_ready while req_valid=0 shall be ignored.

Reset
REQ-021 rst shall asynchronously force: synchronizers, debounced levels and counters to 0; pending=0; req_valid=0; req_floor=0; state=IDLE; last_grant=7 (first search starts at floor 1).
REQ-022 rst asserted mid-OFFER shall drop req_valid immediately and discard all pending requests.

Configuration
REQ-023 Macro CUR_FLOOR_FILTER_EN: when defined, input port cur_floor (3 bits) shall exist and a debounced press for floor==cur_floor shall not set its pending bit; cur_floor=0 disables filtering.
REQ-024 Without CUR_FLOOR_FILTER_EN, port cur_floor shall be absent and all presses shall latch per REQ-012.

Structure
REQ-025 Shared package elev_pkg shall hold NUM_FLOORS, the 3-bit floor type and FSM state encoding (IDLE=0, OFFER=1).
REQ-026 Sub-module btn_debounce (synchronizer, counter, debounced level, rise pulse) shall be instantiated once per button via generate.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 btn[2] high 10 cycles, req_ready=1 -> one grant req_floor=3, pending returns to 0, no second request.
REQ-028 btn[0] glitch high 3 cycles -> pending stays 0, req_valid never asserts.
REQ-029 btn[1], btn[4], btn[6] pressed together, req_ready=1 -> grants 2, 5, 7 in order, each req_valid pulse one cycle with one idle cycle between.
REQ-030 Floor 4 offered, req_ready=0 for 20 cycles, btn[0] pressed meanwhile -> req_floor holds 4; after accept, next grant is 1 (wrap).
REQ-031 rst pulse during OFFER of floor 6 -> req_valid=0, pending=0 asynchronously; next press of floor 2 grants 2 first.
REQ-032 With CUR_FLOOR_FILTER_EN, cur_floor=3, press btn[2] then btn[3] -> only floor 4 granted.
